tri_root: RTL and testbench

TRI_ROOT -- requirements
Module: tri_root

---
 rtl/tri_root_pkg.sv | 16 +
 rtl/tri_root_if.sv | 33 +++
 rtl/tri_root_datapath.sv | 45 ++++
 rtl/tri_root.sv | 90 +++++++++
 tb/tb_tri_root.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_root_pkg.sv
// Shared widths and controller state encoding for the triangular-root decoder.
package tri_root_pkg;

    localparam int unsigned VALUE_W = 13;
    localparam int unsigned N_W     = 7;
    localparam int unsigned REM_W   = 8;
    // k reaches 128 on the worst-case operand, one bit wider than n_out
    localparam int unsigned K_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/tri_root_if.sv
// Request/result bundle between a requester and the triangular-root decoder.
interface tri_root_if;
    import tri_root_pkg::*;

    logic               start;
    logic [VALUE_W-1:0] value;
    logic [N_W-1:0]     n_out;
    logic [REM_W-1:0]   rem_out;
    logic               exact;
    logic               busy;
    logic               finish;

    modport master (
        output start,
        output value,
        input  n_out,
        input  rem_out,
        input  exact,
        input  busy,
        input  finish
    );

    modport slave (
        input  start,
        input  value,
        output n_out,
        output rem_out,
        output exact,
        output busy,
        output finish
    );

endinterface

// File: rtl/tri_root_datapath.sv
// Running remainder and next triangular step: rem -= k, k += 1 while rem >= k.
module tri_root_datapath
    import tri_root_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [VALUE_W-1:0] value,
    output logic               ge,
    output logic [VALUE_W-1:0] rem,
    output logic [K_W-1:0]     k
);

    logic [VALUE_W-1:0] rem_q, rem_d;
    logic [K_W-1:0]     k_q, k_d;

    always_comb begin
        rem_d = rem_q;
        k_d   = k_q;
        if (load) begin
            rem_d = value;
            k_d   = K_W'(1);
        end else if (step) begin
            // step is only issued when ge holds, so neither register wraps
            rem_d = rem_q - VALUE_W'(k_q);
            k_d   = k_q + K_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            k_q   <= '0;
        end else begin
            rem_q <= rem_d;
            k_q   <= k_d;
        end
    end

    assign ge  = rem_q >= VALUE_W'(k_q);
    assign rem = rem_q;
    assign k   = k_q;

endmodule

// File: rtl/tri_root.sv
// Triangular-root decoder: finds the largest n with n(n+1)/2 <= value, plus remainder.
module tri_root
    import tri_root_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    tri_root_if.slave  bus
);

    state_e state_q, state_d;

    logic               load;
    logic               step;
    logic               latch;
    logic               ge;
    logic [VALUE_W-1:0] rem;
    logic [K_W-1:0]     k;

    logic [N_W-1:0]   n_out_q;
    logic [REM_W-1:0] rem_out_q;
    logic             exact_q;

    tri_root_datapath u_datapath (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .value (bus.value),
        .ge    (ge),
        .rem   (rem),
        .k     (k)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ge) begin
                    step = 1'b1;
                end else begin
                    latch   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Final rem < k <= 128, so narrowing to REM_W and k-1 to N_W loses nothing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_out_q   <= '0;
            rem_out_q <= '0;
            exact_q   <= 1'b0;
        end else if (latch) begin
            n_out_q   <= N_W'(k - K_W'(1));
            rem_out_q <= REM_W'(rem);
            exact_q   <= (rem == '0);
        end
    end

    assign bus.n_out   = n_out_q;
    assign bus.rem_out = rem_out_q;
    assign bus.exact   = exact_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.finish  = (state_q == DONE);

endmodule

// File: tb/tb_tri_root.sv
// Directed self-checking bench for tri_root.
module tb_tri_root;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    tri_root_if bus ();

    tri_root dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept on the next rising edge (edge 0), then observe at each falling edge.
    // fin_edge is the edge on which DONE was entered, -1 if never seen.
    task automatic do_decode(input logic [12:0] val, output int fin_edge,
                             output int busy_cnt, output int fin_cnt);
        bus.value = val;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        fin_edge  = -1;
        busy_cnt  = 0;
        fin_cnt   = 0;
        for (int e = 0; e < 300; e++) begin
            if (bus.busy) busy_cnt++;
            if (bus.finish) begin
                fin_cnt++;
                if (fin_edge < 0) fin_edge = e;
            end
            if (!bus.busy) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.n_out, bus.rem_out, bus.exact, bus.finish, bus.busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got n=%0d rem=%0d exact=%b finish=%b busy=%b, want all 0",
                     bus.n_out, bus.rem_out, bus.exact, bus.finish, bus.busy);
        end
        checks++;
        if (dut.rem !== 13'd0 || dut.k !== 8'd0) begin
            failures++;
            $display("FAIL reset_internal: got rem=%0d k=%0d, want 0 0", dut.rem, dut.k);
        end
        rst = 1'b1;
    endtask

    task automatic test_5050;
        int fe, bc, fc;
        do_decode(13'd5050, fe, bc, fc);
        checks++;
        if (bus.n_out !== 7'd100 || bus.rem_out !== 8'd0 || bus.exact !== 1'b1) begin
            failures++;
            $display("FAIL v5050_result: got n=%0d rem=%0d exact=%b, want 100 0 1",
                     bus.n_out, bus.rem_out, bus.exact);
        end
        checks++;
        if (fe !== 101 || fc !== 1 || bc !== 102) begin
            failures++;
            $display("FAIL v5050_timing: got finish_edge=%0d pulses=%0d busy=%0d, want 101 1 102",
                     fe, fc, bc);
        end
    endtask

    task automatic test_8191;
        int fe, bc, fc;
        do_decode(13'd8191, fe, bc, fc);
        checks++;
        if (bus.n_out !== 7'd127 || bus.rem_out !== 8'd63 || bus.exact !== 1'b0) begin
            failures++;
            $display("FAIL v8191_result: got n=%0d rem=%0d exact=%b, want 127 63 0",
                     bus.n_out, bus.rem_out, bus.exact);
        end
        checks++;
        if (fe !== 128 || fc !== 1) begin
            failures++;
            $display("FAIL v8191_timing: got finish_edge=%0d pulses=%0d, want 128 1", fe, fc);
        end
    endtask

    task automatic test_small;
        int fe, bc, fc;
        do_decode(13'd9, fe, bc, fc);
        checks++;
        if (bus.n_out !== 7'd3 || bus.rem_out !== 8'd3 || bus.exact !== 1'b0 || fe !== 4) begin
            failures++;
            $display("FAIL v9: got n=%0d rem=%0d exact=%b edge=%0d, want 3 3 0 4",
                     bus.n_out, bus.rem_out, bus.exact, fe);
        end
        do_decode(13'd10, fe, bc, fc);
        checks++;
        if (bus.n_out !== 7'd4 || bus.rem_out !== 8'd0 || bus.exact !== 1'b1 || fe !== 5) begin
            failures++;
            $display("FAIL v10: got n=%0d rem=%0d exact=%b edge=%0d, want 4 0 1 5",
                     bus.n_out, bus.rem_out, bus.exact, fe);
        end
    endtask

    // value=0: RUN for one cycle, DONE for one; finish high between edges 1 and 2
    task automatic test_zero;
        int fe, bc, fc;
        do_decode(13'd0, fe, bc, fc);
        checks++;
        if (bus.n_out !== 7'd0 || bus.rem_out !== 8'd0 || bus.exact !== 1'b1) begin
            failures++;
            $display("FAIL v0_result: got n=%0d rem=%0d exact=%b, want 0 0 1",
                     bus.n_out, bus.rem_out, bus.exact);
        end
        checks++;
        if (fe !== 1 || bc !== 2 || fc !== 1) begin
            failures++;
            $display("FAIL v0_timing: got finish_edge=%0d busy=%0d pulses=%0d, want 1 2 1",
                     fe, bc, fc);
        end
    endtask

    task automatic test_ignore_start;
        int fc, fe;
        bus.value = 13'd36;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.value = 13'd5000;
        fc = 0;
        fe = -1;
        for (int e = 0; e <= 11; e++) begin
            if (bus.finish) begin
                fc++;
                fe = e;
            end
            if (e == 10) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.n_out !== 7'd8 || bus.rem_out !== 8'd0
                    || bus.exact !== 1'b1) begin
                    failures++;
                    $display("FAIL v36_result: got busy=%b n=%0d rem=%0d exact=%b, want 0 8 0 1",
                             bus.busy, bus.n_out, bus.rem_out, bus.exact);
                end
            end
            if (e == 11) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.finish !== 1'b0) begin
                    failures++;
                    $display("FAIL held_start_restart: got busy=%b finish=%b, want 1 0",
                             bus.busy, bus.finish);
                end
                bus.start = 1'b0;
            end
            if (e == 3) bus.start = 1'b1;
            if (e == 4) bus.start = 1'b0;
            if (e == 9) bus.start = 1'b1;
            if (e < 11) @(negedge clk);
        end
        checks++;
        if (fc !== 1 || fe !== 9) begin
            failures++;
            $display("FAIL v36_single_finish: got pulses=%0d edge=%0d, want 1 9", fc, fe);
        end
        fc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.finish) begin
                fc = 1;
                break;
            end
        end
        checks++;
        if (fc !== 1 || bus.n_out !== 7'd99 || bus.rem_out !== 8'd50 || bus.exact !== 1'b0) begin
            failures++;
            $display("FAIL v5000_restart: got seen=%0d n=%0d rem=%0d exact=%b, want 1 99 50 0",
                     fc, bus.n_out, bus.rem_out, bus.exact);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int fe, bc, fc;
        bus.value = 13'd5050;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.n_out, bus.rem_out, bus.exact, bus.finish, bus.busy} !== '0
            || dut.rem !== 13'd0 || dut.k !== 8'd0) begin
            failures++;
            $display("FAIL mid_run_reset: got n=%0d rem=%0d exact=%b finish=%b busy=%b, want all 0",
                     bus.n_out, bus.rem_out, bus.exact, bus.finish, bus.busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        fc  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.finish || bus.busy) fc++;
        end
        checks++;
        if (fc !== 0) begin
            failures++;
            $display("FAIL no_finish_after_reset: got %0d active cycles, want 0", fc);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        // start presented with reset release: accepted on the very next rising edge
        do_decode(13'd1, fe, bc, fc);
        checks++;
        if (bus.n_out !== 7'd1 || bus.rem_out !== 8'd0 || bus.exact !== 1'b1 || fe !== 2) begin
            failures++;
            $display("FAIL v1_after_reset: got n=%0d rem=%0d exact=%b edge=%0d, want 1 0 1 2",
                     bus.n_out, bus.rem_out, bus.exact, fe);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_5050();
        test_8191();
        test_small();
        test_zero();
        test_ignore_start();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
